// File: rtl/spin_lfsr_pkg.sv
// spin_lfsr_pkg: shared state encoding, default tap masks and the LFSR step function
package spin_lfsr_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;

   // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
   // Values are carried in 64 bits; callers truncate to their width.
   function automatic logic [63:0] lfsr_next(input logic [63:0] q, input logic [63:0] taps,
                                              input int unsigned width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return ((q << 1) | {63'd0, ^(q & taps)}) & mask;
   endfunction

endpackage

// File: rtl/spin_down_counter.sv
// spin_down_counter: loadable down-counter that saturates at zero and flags a count of one
module spin_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic             clr,
   input  logic             dec,
   input  logic [CNT_W-1:0] ld_val,
   output logic             is_one
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   // clear beats load beats decrement; decrement only from nonzero so it never wraps
   always_comb begin
      cnt_d = clr ? '0 : ld ? ld_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   end

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spin_lfsr.sv
// spin_lfsr: presettable Fibonacci LFSR that spins for a programmed number of steps then pulses done
module spin_lfsr
   import spin_lfsr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = (WIDTH == 16) ? WIDTH'(TAPS_16) : WIDTH'(TAPS_8),
   parameter logic [WIDTH-1:0] RESET_VAL = '1,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] spin_len,
   input  logic             step,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   state_t           state_d, state_q;
   logic [WIDTH-1:0] q_d, q_q, nxt, seed_fix;
   logic             cnt_ld, cnt_clr, cnt_dec, cnt_is_one;
   logic             busy_q, done_q;

   assign nxt      = WIDTH'(lfsr_next(64'(q_q), 64'(TAPS), WIDTH));
   assign seed_fix = (seed == '0) ? RESET_VAL : seed;

   spin_down_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .ld     (cnt_ld),
      .clr    (cnt_clr),
      .dec    (cnt_dec),
      .ld_val (spin_len),
      .is_one (cnt_is_one)
   );

   // next state, next LFSR value and counter controls; load always wins
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_ld  = 1'b0;
      cnt_clr = 1'b0;
      cnt_dec = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) q_d = seed_fix;
            else if (start && spin_len != '0) begin
               cnt_ld  = 1'b1;
               state_d = RUN;
            end
            else if (start) state_d = DONE;
            else if (step && en) q_d = nxt;
         end
         RUN: begin
            if (load) begin
               q_d     = seed_fix;
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
            else if (en) begin
               q_d     = nxt;
               cnt_dec = 1'b1;
               state_d = cnt_is_one ? DONE : RUN;
            end
         end
         DONE: begin
            q_d     = load ? seed_fix : q_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state, LFSR and registered status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= RESET_VAL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end
      else begin
         state_q <= state_d;
         q_q     <= q_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign q    = q_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_spin_lfsr.sv
// tb_spin_lfsr: directed checks of reset, manual stepping, spins, stalls, aborts, zero handling and period
module tb_spin_lfsr;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] seed = 8'h00;
   logic       start = 1'b0;
   logic [7:0] spin_len = 8'h00;
   logic       step = 1'b0;
   logic [7:0] q;
   logic       busy, done;
   int         total = 0;
   int         bad = 0;
   logic [7:0] seq [0:5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

   spin_lfsr dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed), .start(start),
      .spin_len(spin_len), .step(step), .q(q), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reseed_ff();
      load = 1'b1; seed = 8'hFF;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_init q=%h busy=%b done=%b want FF 0 0", q, busy, done);
      end
      en = 1'b1; start = 1'b1; spin_len = 8'd5;
      tick();
      start = 1'b0;
      tick();
      total++;
      if (q !== 8'hFE || busy !== 1'b1) begin
         bad++; $display("FAIL reset_prespin q=%h busy=%b want FE 1", q, busy);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_async q=%h busy=%b done=%b want FF 0 0", q, busy, done);
      end
      #1 reset = 1'b0;
      tick();
      tick();
      total++;
      if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_after q=%h busy=%b done=%b want FF 0 0", q, busy, done);
      end
   endtask

   task automatic test_manual_steps();
      en = 1'b1; step = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         total++;
         if (q !== seq[i] || busy !== 1'b0) begin
            bad++; $display("FAIL step_%0d q=%h busy=%b want %h 0", i, q, busy, seq[i]);
         end
      end
      step = 1'b0; en = 1'b0;
      tick();
      total++;
      if (q !== 8'hE1) begin
         bad++; $display("FAIL step_hold q=%h want E1", q);
      end
      en = 1'b1; step = 1'b1; start = 1'b0;
      en = 1'b0;
      tick();
      step = 1'b0;
      total++;
      if (q !== 8'hE1) begin
         bad++; $display("FAIL step_gated q=%h want E1", q);
      end
   endtask

   task automatic test_spin();
      reseed_ff();
      en = 1'b1; start = 1'b1; spin_len = 8'd5; step = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (q !== 8'hFF || busy !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL spin_start q=%h busy=%b done=%b want FF 1 0", q, busy, done);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         total++;
         if (i < 5 && (q !== seq[i] || busy !== 1'b1 || done !== 1'b0)) begin
            bad++; $display("FAIL spin_run_%0d q=%h busy=%b done=%b want %h 1 0", i, q, busy, done, seq[i]);
         end
         else if (i == 5 && (q !== 8'hE1 || busy !== 1'b0 || done !== 1'b1)) begin
            bad++; $display("FAIL spin_done q=%h busy=%b done=%b want E1 0 1", q, busy, done);
         end
      end
      step = 1'b0;
      tick();
      total++;
      if (q !== 8'hE1 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL spin_after q=%h busy=%b done=%b want E1 0 0", q, busy, done);
      end
   endtask

   task automatic test_stall_abort();
      int n;
      reseed_ff();
      en = 1'b1; start = 1'b1; spin_len = 8'd4;
      tick();
      start = 1'b0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (!busy) break;
         n++;
         en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
         tick();
      end
      en = 1'b1;
      total++;
      if (n !== 6 || done !== 1'b1 || q !== 8'hF0) begin
         bad++; $display("FAIL stall busy_cycles=%0d done=%b q=%h want 6 1 F0", n, done, q);
      end
      reseed_ff();
      start = 1'b1; spin_len = 8'd10;
      tick();
      start = 1'b0;
      tick();
      tick();
      load = 1'b1; seed = 8'h3C;
      tick();
      load = 1'b0;
      total++;
      if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL abort q=%h busy=%b done=%b want 3C 0 0", q, busy, done);
      end
      n = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) n++;
         tick();
      end
      total++;
      if (n !== 0 || q !== 8'h3C) begin
         bad++; $display("FAIL abort_quiet flag_cycles=%0d q=%h want 0 3C", n, q);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      total++;
      if (q !== 8'h79) begin
         bad++; $display("FAIL abort_idle_step q=%h want 79", q);
      end
   endtask

   task automatic test_zero();
      load = 1'b1; seed = 8'h00;
      tick();
      load = 1'b0;
      total++;
      if (q !== 8'hFF) begin
         bad++; $display("FAIL zero_seed q=%h want FF", q);
      end
      en = 1'b1; start = 1'b1; spin_len = 8'd0;
      tick();
      start = 1'b0;
      total++;
      if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b1) begin
         bad++; $display("FAIL zero_len q=%h busy=%b done=%b want FF 0 1", q, busy, done);
      end
      tick();
      total++;
      if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL zero_len_after q=%h busy=%b done=%b want FF 0 0", q, busy, done);
      end
      start = 1'b1;
      tick();
      start = 1'b0; load = 1'b1; seed = 8'h55;
      tick();
      load = 1'b0;
      total++;
      if (q !== 8'h55 || done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL done_load q=%h busy=%b done=%b want 55 0 0", q, busy, done);
      end
   endtask

   task automatic test_period();
      logic [255:0] seen;
      reseed_ff();
      seen = '0;
      seen[8'hFF] = 1'b1;
      en = 1'b1; step = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (i < 255) begin
            total++;
            if (q === 8'h00 || seen[q]) begin
               bad++; $display("FAIL period_step_%0d q=%h repeated_or_zero", i, q);
            end
            seen[q] = 1'b1;
         end
      end
      step = 1'b0;
      total++;
      if (q !== 8'hFF) begin
         bad++; $display("FAIL period_wrap q=%h want FF", q);
      end
   endtask

   initial begin
      #12 reset = 1'b0;
      tick();
      test_reset();
      test_manual_steps();
      test_spin();
      test_stall_abort();
      test_zero();
      test_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
